// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry pipeline register with a skid slot and a synchronous flush.
//   The main register drives the output. The skid register catches one extra
//   entry when downstream stalls, so in_ready can be a plain flop with no
//   combinational path from out_ready. Flush (clr) zeroes the clearable
//   payload, keeps the retained payload on the output and empties the block.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-high reset
//   clr        : synchronous flush, highest priority after reset
//   in_valid   : upstream offers an entry
//   in_ready   : block accepts an entry this cycle (registered)
//   in_data    : clearable payload in  [DATA_W-1:0]
//   in_keep    : retained payload in   [KEEP_W-1:0]
//   out_valid  : head entry valid (registered)
//   out_ready  : downstream consumes the head entry
//   out_data   : clearable payload of the head entry
//   out_keep   : retained payload of the head entry
//   occupancy  : number of held entries, 0..2
// ----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [1:0]        occupancy
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [KEEP_W-1:0] main_keep_q, main_keep_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [KEEP_W-1:0] skid_keep_q, skid_keep_d;

  logic fire_in_s;
  logic fire_out_s;

  assign fire_in_s  = in_valid & in_ready_q;
  assign fire_out_s = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_keep  = main_keep_q;
  assign occupancy = state_q;

  // Next-state and next-payload selection; clr overrides every handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_keep_d = main_keep_q;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    if (clr) begin
      // Bubble insertion: output keep stays visible, everything else cleared.
      state_d     = ST_EMPTY;
      main_data_d = {DATA_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
      skid_keep_d = {KEEP_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fire_in_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_keep_d = in_keep;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (fire_in_s && fire_out_s) begin
            main_data_d = in_data;
            main_keep_d = in_keep;
          end else if (fire_in_s) begin
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_keep_d = in_keep;
          end else if (fire_out_s) begin
            // Output payload holds its last value while empty.
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path can happen.
          if (out_ready) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_keep_d = skid_keep_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= {DATA_W{1'b0}};
      main_keep_q <= {KEEP_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_keep_q <= {KEEP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      // Derived from next state so in_ready never depends on out_ready combinationally.
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      main_data_q <= main_data_d;
      main_keep_q <= main_keep_d;
      skid_data_q <= skid_data_d;
      skid_keep_q <= skid_keep_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Self-checking bench for pipe_skid_reg. The reference model is an ordered
//   queue of at most two entries plus the value last shown on the output.
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 32;

  logic              clk;
  logic              reset;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic [1:0]        occupancy;

  int total;
  int bad;

  // Reference model: FIFO of held entries, and what the output shows.
  logic [DATA_W-1:0] m_data[$];
  logic [KEEP_W-1:0] m_keep[$];
  logic [DATA_W-1:0] shown_data;
  logic [KEEP_W-1:0] shown_keep;

  pipe_skid_reg #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_keep.delete();
    shown_data = 32'h0;
    shown_keep = 32'h0;
  endtask

  task automatic check_model(input string ph);
    chk({ph, ":out_valid"}, {31'h0, out_valid}, {31'h0, (m_data.size() > 0)});
    chk({ph, ":occupancy"}, {30'h0, occupancy}, m_data.size());
    chk({ph, ":in_ready"},  {31'h0, in_ready},  {31'h0, (m_data.size() < 2)});
    chk({ph, ":out_data"},  out_data, shown_data);
    chk({ph, ":out_keep"},  out_keep, shown_keep);
  endtask

  // Drive one cycle (called just after a falling edge), advance the model,
  // then check all outputs on the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [31:0] k,
                       input logic ordy, input logic c, input string ph);
    bit accept;
    in_valid  = v;
    in_data   = d;
    in_keep   = k;
    out_ready = ordy;
    clr       = c;
    if (c) begin
      m_data.delete();
      m_keep.delete();
      shown_data = 32'h0;
    end else begin
      accept = v && (m_data.size() < 2);
      if (ordy && m_data.size() > 0) begin
        void'(m_data.pop_front());
        void'(m_keep.pop_front());
      end
      if (accept) begin
        m_data.push_back(d);
        m_keep.push_back(k);
      end
    end
    if (m_data.size() > 0) begin
      shown_data = m_data[0];
      shown_keep = m_keep[0];
    end
    @(negedge clk);
    check_model(ph);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_keep   = 32'h0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    reset = 1'b0;

    // Single entry, one-cycle latency.
    cycle(1'b1, 32'h11, 32'h400, 1'b1, 1'b0, "single");
    chk("single:data_const", out_data, 32'h11);
    chk("single:keep_const", out_keep, 32'h400);
    chk("single:occ_const", {30'h0, occupancy}, 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
    chk("drain:hold_data", out_data, 32'h11);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, i, 32'h200 + i, 1'b1, 1'b0, "stream");
      chk("stream:data_const", out_data, i);
      chk("stream:in_ready", {31'h0, in_ready}, 32'd1);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "stream_end");

    // Back-pressure, order kept with no loss.
    cycle(1'b1, 32'hA, 32'h100, 1'b0, 1'b0, "bp_a");
    cycle(1'b1, 32'hB, 32'h104, 1'b0, 1'b0, "bp_b");
    chk("bp:occ_full", {30'h0, occupancy}, 32'd2);
    chk("bp:in_ready_low", {31'h0, in_ready}, 32'd0);
    cycle(1'b1, 32'hC, 32'h108, 1'b0, 1'b0, "bp_c_held");
    cycle(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, "bp_pop_a");
    chk("bp:second_b", out_data, 32'hB);
    cycle(1'b1, 32'hC, 32'h108, 1'b1, 1'b0, "bp_pop_b");
    chk("bp:third_c", out_data, 32'hC);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp_pop_c");

    // Flush while full.
    cycle(1'b1, 32'hA, 32'h100, 1'b0, 1'b0, "clr_a");
    cycle(1'b1, 32'hB, 32'h104, 1'b0, 1'b0, "clr_b");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "clr");
    chk("clr:data_zero", out_data, 32'h0);
    chk("clr:keep_kept", out_keep, 32'h100);
    chk("clr:in_ready", {31'h0, in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "clr_idle");

    // Entry offered on a flush cycle is dropped.
    cycle(1'b1, 32'h55, 32'h500, 1'b1, 1'b1, "clr_drop");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "clr_drop2");
    chk("clr_drop:no_valid", {31'h0, out_valid}, 32'd0);

    // Asynchronous reset while full, checked before the next rising edge.
    cycle(1'b1, 32'h77, 32'h700, 1'b0, 1'b0, "ar_a");
    cycle(1'b1, 32'h78, 32'h704, 1'b0, 1'b0, "ar_b");
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset:out_valid", {31'h0, out_valid}, 32'd0);
    chk("areset:occupancy", {30'h0, occupancy}, 32'd0);
    chk("areset:out_data", out_data, 32'h0);
    chk("areset:out_keep", out_keep, 32'h0);
    chk("areset:in_ready", {31'h0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_model("post_reset");

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL take parameter DATA_W, default 32: width of the payload zeroed on flush (ALU result, instruction, control bits).
REQ-002 SHALL take parameter KEEP_W, default 32: width of the payload retained on flush (PC, PC+4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous flush (bubble insertion).
REQ-006 SHALL have port in_valid  input  1  upstream stage presents a valid entry.
REQ-007 SHALL have port in_ready  output  1  block can accept an entry this cycle; driven from a register.
REQ-008 SHALL have port in_data  input  DATA_W  clearable payload.
REQ-009 SHALL have port in_keep  input  KEEP_W  retained payload.
REQ-010 SHALL have port out_valid  output  1  output entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream stage consumes the output entry.
REQ-012 SHALL have port out_data  output  DATA_W  clearable payload of the head entry.
REQ-013 SHALL have port out_keep  output  KEEP_W  retained payload of the head entry.
REQ-014 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 SHALL hold two entries: a main register, which drives out_*, and a skid register.
REQ-016 SHALL define fire_in = in_valid & in_ready and fire_out = out_valid & out_ready.
REQ-017 SHALL implement states EMPTY (occupancy 0), ONE (1) and FULL (2); out_valid=1 exactly in ONE and FULL.
REQ-018 In EMPTY with fire_in, SHALL load main from in_* and go to ONE; latency input to output is 1 cycle.
REQ-019 In ONE with fire_in & fire_out, SHALL load main from in_* and stay in ONE, sustaining 1 entry per cycle.
REQ-020 In ONE with fire_in only, SHALL load skid from in_* and go to FULL.
REQ-021 In ONE with fire_out only, SHALL go to EMPTY.
REQ-022 In FULL with out_ready=1, SHALL move skid into main and go to ONE.
REQ-023 SHALL drive in_ready=0 whenever the next state is FULL, and 1 otherwise; in_valid is ignored in FULL.
REQ-024 SHALL preserve entry order: no entry is dropped, duplicated or reordered unless clr is asserted.
REQ-025 When going to EMPTY via fire_out, out_data and out_keep SHALL hold their last values.
REQ-026 clr SHALL take priority over all other events: next state EMPTY, occupancy 0, main and skid data fields <= 0, out_keep retained, skid keep discarded.
REQ-027 Any entry offered on the clr cycle SHALL be dropped, even if in_ready=1.
REQ-028 in_ready SHALL be 1 in the cycle after clr.
REQ-029 out_valid=0 SHALL be the only signal of an empty block; out_ready while empty SHALL have no effect.
REQ-030 SHALL contain no combinational path from out_ready to in_ready.

Reset
REQ-031 While reset=1, SHALL immediately force state EMPTY, out_valid=0, in_ready=1, occupancy=0, and out_data, out_keep and both skid fields to 0, independent of clk.
REQ-032 SHALL discard any in-flight entries when reset is asserted mid-operation; first acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-033 Reset, then in_valid=1, in_data=0x11, in_keep=0x400 for one cycle with out_ready=1 -> next cycle out_valid=1, out_data=0x11, out_keep=0x400, occupancy=1.
REQ-034 Stream 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> outputs 0x1..0x4 on consecutive cycles; in_ready stays 1.
REQ-035 out_ready=0, offer 0xA then 0xB -> occupancy=2, in_ready=0; 0xC is held upstream; raise out_ready -> output order 0xA, 0xB, 0xC with no loss.
REQ-036 Full with data 0xA/0xB, keep 0x100/0x104, assert clr -> next cycle out_valid=0, out_data=0, out_keep=0x100, occupancy=0, in_ready=1.
REQ-037 clr and in_valid=1 (data 0x55) in the same cycle while EMPTY -> 0x55 never appears; out_valid stays 0.
REQ-038 Assert reset asynchronously between clock edges while FULL -> out_valid=0, occupancy=0, out_data=0 and out_keep=0 immediately, without waiting for clk.
